time_entry_ctrl: RTL
====================

TIME_ENTRY_CTRL -- requirements
Module: time_entry_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port key_valid, input, 1 bit: one-cycle strobe qualifying key_code.
REQ-004 SHALL have port key_code, input, 4 bits: 0-9 = digit, 10 = LOAD, 11 = CLEAR, 12-15 = ignored.
REQ-005 SHALL have port one_second, input, 1 bit: one-cycle timebase tick used for entry timeout.
REQ-006 SHALL have port load_new_c, output, 1 bit: one-cycle commit pulse to the time counter.
REQ-007 SHALL have ports new_current_time_ms_hr, new_current_time_ls_hr, new_current_time_ms_min and new_current_time_ls_min, each output, 4 bits, BCD: the entry buffer digits.
REQ-008 SHALL have port entry_active, output, 1 bit: high while in ENTRY.
REQ-009 SHALL have port entry_error, output, 1 bit: one-cycle pulse when a commit is rejected.

Function
REQ-010 SHALL implement the FSM states IDLE, ENTRY and COMMIT.
REQ-011 SHALL, on a digit key in IDLE, clear the buffer, place the digit in ls_min, set digit_count=1 and go to ENTRY.
REQ-012 SHALL, on a digit key in ENTRY, shift left (ms_hr<-ls_hr<-ms_min<-ls_min<-key), discard the oldest digit and saturate digit_count at 4.
REQ-013 SHALL, on LOAD in ENTRY with digit_count==4 and a valid time, go to COMMIT.
REQ-014 SHALL define a valid time as: ms_hr<=2; ls_hr<=3 if ms_hr==2, else ls_hr<=9; ms_min<=5; ls_min<=9.
REQ-015 SHALL assert load_new_c for exactly one cycle in COMMIT (LOAD accepted at edge N -> load_new_c high for cycle N+1), then go to IDLE.
REQ-016 SHALL hold new_current_time_* stable from the LOAD edge through the load_new_c cycle; the buffer is retained in IDLE after a commit.
REQ-017 SHALL, on LOAD in ENTRY with an invalid time or digit_count<4, pulse entry_error for one cycle, clear the buffer to 0000 and go to IDLE, with no load_new_c.
REQ-018 SHALL ignore LOAD in IDLE.
REQ-019 SHALL, on CLEAR in IDLE or ENTRY, clear the buffer and digit_count and go to IDLE.
REQ-020 SHALL ignore all keys while in COMMIT.
REQ-021 SHALL ignore key_code 12-15 with no state change, except that in ENTRY they restart the timeout counter.
REQ-022 SHALL drive entry_active=1 only in ENTRY.

Reset
REQ-023 SHALL, while reset is low, force state=IDLE, buffer=0000, digit_count=0, timeout counter=0 and load_new_c=entry_active=entry_error=0.
REQ-024 SHALL abort any entry or commit in progress when reset asserts mid-operation; no load_new_c pulse is issued afterwards.

Configuration
REQ-025 SHALL, with macro ENTRY_TIMEOUT_EN defined, count one_second ticks in ENTRY and reset the count on any key_valid.
REQ-026 SHALL, with ENTRY_TIMEOUT_EN defined, on the 10th tick clear the buffer and go to IDLE with no load_new_c and no entry_error.
REQ-027 SHALL, with ENTRY_TIMEOUT_EN defined, let key_valid win when it coincides with the 10th tick: the key is processed and the count resets.
REQ-028 SHALL, without ENTRY_TIMEOUT_EN, keep the one_second port but ignore it, so ENTRY persists until LOAD, CLEAR or reset.

Verification
REQ-029 SHALL cover: keys 1,4,3,7,LOAD -> one load_new_c pulse one cycle after LOAD, outputs 1,4,3,7.
REQ-030 SHALL cover: keys 2,4,0,0,LOAD -> entry_error pulse, no load_new_c, outputs 0000, entry_active=0.
REQ-031 SHALL cover: keys 9,1,2,3,5,LOAD (5 digits) -> commits 12:35; digit 9 discarded.
REQ-032 SHALL cover: keys 0,8,CLEAR,LOAD -> no pulse, outputs 0000, IDLE.
REQ-033 SHALL cover, with ENTRY_TIMEOUT_EN: key 1 then 10 one_second ticks -> entry_active falls, buffer 0000; with key_valid coincident on the 10th tick -> stays in ENTRY.
REQ-034 SHALL cover: reset low for one cycle during COMMIT -> load_new_c=0 throughout, all outputs 0.

Source files
------------

// File: rtl/time_entry_ctrl.sv
// time_entry_ctrl: keypad time-entry controller.
// Collects four BCD digits (HH:MM), validates them on LOAD and issues a
// one-cycle load_new_c commit pulse to the time counter. An invalid or
// short entry is rejected with a one-cycle entry_error pulse.
// Optional feature: define ENTRY_TIMEOUT_EN to abandon an entry after ten
// one_second ticks without a key; otherwise one_second is ignored.
module time_entry_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       one_second,
  output logic       load_new_c,
  output logic [3:0] new_current_time_ms_hr,
  output logic [3:0] new_current_time_ls_hr,
  output logic [3:0] new_current_time_ms_min,
  output logic [3:0] new_current_time_ls_min,
  output logic       entry_active,
  output logic       entry_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [3:0] KEY_LOAD  = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;

  state_t      state_q, state_d;
  // Entry buffer packed as {ms_hr, ls_hr, ms_min, ls_min}.
  logic [15:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        load_q, load_d;
  logic        err_q, err_d;
  logic        active_q, active_d;

  logic        is_digit, is_load, is_clear;
  logic        time_valid;

`ifdef ENTRY_TIMEOUT_EN
  logic [3:0]  tmo_q, tmo_d;
`else
  // The tick is deliberately unused in this build; entry never times out.
  logic        unused_one_second;
  assign unused_one_second = one_second;
`endif

  assign is_digit = (key_code <= 4'd9);
  assign is_load  = (key_code == KEY_LOAD);
  assign is_clear = (key_code == KEY_CLEAR);

  // Range check of the buffered HH:MM; 24-hour clock, 00:00 .. 23:59.
  always_comb begin
    time_valid = (buf_q[15:12] <= 4'd2) &&
                 ((buf_q[15:12] == 4'd2) ? (buf_q[11:8] <= 4'd3)
                                         : (buf_q[11:8] <= 4'd9)) &&
                 (buf_q[7:4] <= 4'd5) &&
                 (buf_q[3:0] <= 4'd9);
  end

  // Next-state logic: key decoding, buffer shifting and commit decision.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          if (is_digit) begin
            buf_d   = {12'h000, key_code};
            cnt_d   = 3'd1;
            state_d = ENTRY;
          end else if (is_clear) begin
            buf_d = 16'h0000;
            cnt_d = 3'd0;
          end
        end
      end
      ENTRY: begin
        if (key_valid) begin
`ifdef ENTRY_TIMEOUT_EN
          // Any key, including unused codes, restarts the timeout.
          tmo_d = 4'd0;
`endif
          if (is_digit) begin
            buf_d = {buf_q[11:0], key_code};
            if (cnt_q < 3'd4) cnt_d = cnt_q + 3'd1;
          end else if (is_load) begin
            cnt_d = 3'd0;
            if ((cnt_q == 3'd4) && time_valid) begin
              load_d  = 1'b1;
              state_d = COMMIT;
            end else begin
              err_d   = 1'b1;
              buf_d   = 16'h0000;
              state_d = IDLE;
            end
          end else if (is_clear) begin
            buf_d   = 16'h0000;
            cnt_d   = 3'd0;
            state_d = IDLE;
          end
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (one_second) begin
          if (tmo_q == 4'd9) begin
            buf_d   = 16'h0000;
            cnt_d   = 3'd0;
            tmo_d   = 4'd0;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + 4'd1;
          end
        end
`endif
      end
      COMMIT: begin
        // Keys are ignored; the buffer is kept for the counter to load.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        buf_d   = 16'h0000;
        cnt_d   = 3'd0;
      end
    endcase
`ifdef ENTRY_TIMEOUT_EN
    if (state_d != ENTRY) tmo_d = 4'd0;
`endif
    active_d = (state_d == ENTRY);
  end

  // State and registered outputs; reset aborts any entry or commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      buf_q    <= 16'h0000;
      cnt_q    <= 3'd0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      tmo_q    <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      err_q    <= err_d;
      active_q <= active_d;
`ifdef ENTRY_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign load_new_c              = load_q;
  assign entry_error             = err_q;
  assign entry_active            = active_q;
  assign new_current_time_ms_hr  = buf_q[15:12];
  assign new_current_time_ls_hr  = buf_q[11:8];
  assign new_current_time_ms_min = buf_q[7:4];
  assign new_current_time_ls_min = buf_q[3:0];

endmodule
